// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV32I core: captures decoded instructions,
// forwards EX/MEM and MEM/WB results into the ALU operands, and detects load-use hazards.
module id_ex_stage (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        id_valid_i,
  input  logic [31:0] id_pc_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic [4:0]  id_rd_i,
  input  logic        id_uses_rs1_i,
  input  logic        id_uses_rs2_i,
  input  logic [31:0] id_rs1_data_i,
  input  logic [31:0] id_rs2_data_i,
  input  logic [31:0] id_imm_i,
  input  logic [3:0]  id_alu_func_i,
  input  logic [1:0]  id_op1_sel_i,
  input  logic        id_op2_sel_i,
  input  logic        id_reg_we_i,
  input  logic        id_mem_rd_i,
  input  logic        id_mem_wr_i,
  input  logic [4:0]  exm_rd_i,
  input  logic        exm_we_i,
  input  logic [31:0] exm_data_i,
  input  logic [4:0]  mwb_rd_i,
  input  logic        mwb_we_i,
  input  logic [31:0] mwb_data_i,
  input  logic        flush_i,
  input  logic        mem_stall_i,
  output logic        id_stall_o,
  output logic        ex_valid_o,
  output logic [31:0] ex_pc_o,
  output logic [31:0] alu_op1_o,
  output logic [31:0] alu_op2_o,
  output logic [3:0]  alu_func_o,
  output logic [31:0] ex_store_data_o,
  output logic [4:0]  ex_rd_o,
  output logic        ex_reg_we_o,
  output logic        ex_mem_rd_o,
  output logic        ex_mem_wr_o
);

  logic        r_valid;
  logic [31:0] r_pc;
  logic [4:0]  r_rs1, r_rs2, r_rd;
  logic [31:0] r_rs1_data, r_rs2_data, r_imm;
  logic [3:0]  r_func;
  logic [1:0]  r_op1_sel;
  logic        r_op2_sel;
  logic        r_reg_we, r_mem_rd, r_mem_wr;

  logic        w_lu;
  logic        w_bubble;
  logic [31:0] w_fwd_rs1, w_fwd_rs2;

  // A load in EX cannot supply its data until MEM/WB, so a dependent decode instruction waits one cycle.
  assign w_lu = r_valid & r_mem_rd & (r_rd != 5'd0) & id_valid_i &
                ((id_uses_rs1_i & (id_rs1_i == r_rd)) |
                 (id_uses_rs2_i & (id_rs2_i == r_rd)));

  assign w_bubble   = flush_i | w_lu;
  assign id_stall_o = mem_stall_i | (w_lu & ~flush_i);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_func     <= '0;
      r_op1_sel  <= '0;
      r_op2_sel  <= 1'b0;
      r_reg_we   <= 1'b0;
      r_mem_rd   <= 1'b0;
      r_mem_wr   <= 1'b0;
    end else if (mem_stall_i) begin
      r_valid <= r_valid;
    end else if (w_bubble) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_func     <= '0;
      r_op1_sel  <= '0;
      r_op2_sel  <= 1'b0;
      r_reg_we   <= 1'b0;
      r_mem_rd   <= 1'b0;
      r_mem_wr   <= 1'b0;
    end else begin
      r_valid    <= id_valid_i;
      r_pc       <= id_pc_i;
      r_rs1      <= id_rs1_i;
      r_rs2      <= id_rs2_i;
      r_rd       <= id_rd_i;
      r_rs1_data <= id_rs1_data_i;
      r_rs2_data <= id_rs2_data_i;
      r_imm      <= id_imm_i;
      r_func     <= id_alu_func_i;
      r_op1_sel  <= id_op1_sel_i;
      r_op2_sel  <= id_op2_sel_i;
      r_reg_we   <= id_reg_we_i;
      r_mem_rd   <= id_mem_rd_i;
      r_mem_wr   <= id_mem_wr_i;
    end
  end

  // EX/MEM is younger than MEM/WB, so it wins; x0 is hardwired and never forwarded.
  always_comb begin
    w_fwd_rs1 = r_rs1_data;
    if (exm_we_i && exm_rd_i != 5'd0 && exm_rd_i == r_rs1)
      w_fwd_rs1 = exm_data_i;
    else if (mwb_we_i && mwb_rd_i != 5'd0 && mwb_rd_i == r_rs1)
      w_fwd_rs1 = mwb_data_i;

    w_fwd_rs2 = r_rs2_data;
    if (exm_we_i && exm_rd_i != 5'd0 && exm_rd_i == r_rs2)
      w_fwd_rs2 = exm_data_i;
    else if (mwb_we_i && mwb_rd_i != 5'd0 && mwb_rd_i == r_rs2)
      w_fwd_rs2 = mwb_data_i;
  end

  always_comb begin
    case (r_op1_sel)
      2'b00:   alu_op1_o = w_fwd_rs1;
      2'b01:   alu_op1_o = r_pc;
      default: alu_op1_o = 32'd0;
    endcase
  end

  assign alu_op2_o       = r_op2_sel ? r_imm : w_fwd_rs2;
  assign ex_store_data_o = w_fwd_rs2;
  assign ex_valid_o      = r_valid;
  assign ex_pc_o         = r_pc;
  assign ex_rd_o         = r_rd;
  assign alu_func_o      = r_valid ? r_func : 4'd0;
  assign ex_reg_we_o     = r_valid & r_reg_we;
  assign ex_mem_rd_o     = r_valid & r_mem_rd;
  assign ex_mem_wr_o     = r_valid & r_mem_wr;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, forwarding priority, x0, load-use, flush, stall.
module tb_id_ex_stage;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        id_valid_i;
  logic [31:0] id_pc_i;
  logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
  logic        id_uses_rs1_i, id_uses_rs2_i;
  logic [31:0] id_rs1_data_i, id_rs2_data_i, id_imm_i;
  logic [3:0]  id_alu_func_i;
  logic [1:0]  id_op1_sel_i;
  logic        id_op2_sel_i;
  logic        id_reg_we_i, id_mem_rd_i, id_mem_wr_i;
  logic [4:0]  exm_rd_i, mwb_rd_i;
  logic        exm_we_i, mwb_we_i;
  logic [31:0] exm_data_i, mwb_data_i;
  logic        flush_i, mem_stall_i;
  logic        id_stall_o, ex_valid_o;
  logic [31:0] ex_pc_o, alu_op1_o, alu_op2_o, ex_store_data_o;
  logic [3:0]  alu_func_o;
  logic [4:0]  ex_rd_o;
  logic        ex_reg_we_o, ex_mem_rd_o, ex_mem_wr_o;

  int tests  = 0;
  int failed = 0;

  always #5 clk_i = ~clk_i;

  id_ex_stage dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .id_valid_i(id_valid_i), .id_pc_i(id_pc_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
    .id_uses_rs1_i(id_uses_rs1_i), .id_uses_rs2_i(id_uses_rs2_i),
    .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
    .id_imm_i(id_imm_i), .id_alu_func_i(id_alu_func_i),
    .id_op1_sel_i(id_op1_sel_i), .id_op2_sel_i(id_op2_sel_i),
    .id_reg_we_i(id_reg_we_i), .id_mem_rd_i(id_mem_rd_i), .id_mem_wr_i(id_mem_wr_i),
    .exm_rd_i(exm_rd_i), .exm_we_i(exm_we_i), .exm_data_i(exm_data_i),
    .mwb_rd_i(mwb_rd_i), .mwb_we_i(mwb_we_i), .mwb_data_i(mwb_data_i),
    .flush_i(flush_i), .mem_stall_i(mem_stall_i),
    .id_stall_o(id_stall_o), .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o),
    .alu_op1_o(alu_op1_o), .alu_op2_o(alu_op2_o), .alu_func_o(alu_func_o),
    .ex_store_data_o(ex_store_data_o), .ex_rd_o(ex_rd_o),
    .ex_reg_we_o(ex_reg_we_o), .ex_mem_rd_o(ex_mem_rd_o), .ex_mem_wr_o(ex_mem_wr_o)
  );

  task automatic set_id(input logic v, input logic [31:0] pc,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic u1, input logic u2,
                        input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                        input logic [3:0] func, input logic [1:0] s1, input logic s2,
                        input logic we, input logic mrd, input logic mwr);
    id_valid_i = v; id_pc_i = pc; id_rs1_i = rs1; id_rs2_i = rs2; id_rd_i = rd;
    id_uses_rs1_i = u1; id_uses_rs2_i = u2; id_rs1_data_i = d1; id_rs2_data_i = d2;
    id_imm_i = imm; id_alu_func_i = func; id_op1_sel_i = s1; id_op2_sel_i = s2;
    id_reg_we_i = we; id_mem_rd_i = mrd; id_mem_wr_i = mwr;
  endtask

  task automatic clr_fwd();
    exm_rd_i = 0; exm_we_i = 0; exm_data_i = 0;
    mwb_rd_i = 0; mwb_we_i = 0; mwb_data_i = 0;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; flush_i = 0; mem_stall_i = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      set_id(1, 32'h100 + i, 5'd1 + i[4:0], 5'd2, 5'd3, 1, 1, 32'hDEAD0000 + i, 32'h77, 32'h9,
             4'd1, 2'd0, 1'b0, 1, 1, 1);
      exm_rd_i = 5'd1; exm_we_i = 1; exm_data_i = 32'hCAFE0000 + i;
      mwb_rd_i = 5'd2; mwb_we_i = 1; mwb_data_i = 32'hBEEF0000 + i;
      mem_stall_i = i[0];
      @(posedge clk_i); #1;
      tests++;
      if ({ex_valid_o, alu_func_o, ex_reg_we_o, ex_mem_rd_o, ex_mem_wr_o, ex_rd_o} !== 13'd0) begin
        failed++; $display("FAIL reset_ctrl: got %h expected 0",
          {ex_valid_o, alu_func_o, ex_reg_we_o, ex_mem_rd_o, ex_mem_wr_o, ex_rd_o});
      end
      tests++;
      if ({alu_op1_o, alu_op2_o, ex_pc_o, ex_store_data_o} !== 128'd0) begin
        failed++; $display("FAIL reset_data: op1=%h op2=%h pc=%h st=%h expected 0",
          alu_op1_o, alu_op2_o, ex_pc_o, ex_store_data_o);
      end
      tests++;
      if (id_stall_o !== mem_stall_i) begin
        failed++; $display("FAIL reset_stall: got %b expected %b", id_stall_o, mem_stall_i);
      end
    end
    @(negedge clk_i);
    rst_n_i = 1'b1; mem_stall_i = 0; clr_fwd();
    set_id(1, 32'h200, 5'd1, 5'd0, 5'd2, 1, 0, 32'd5, 32'd0, 32'd7, 4'd1, 2'd0, 1'b1, 1, 0, 0);
    @(posedge clk_i); #1;
    tests++;
    if (alu_op1_o !== 32'd5 || alu_op2_o !== 32'd7 || alu_func_o !== 4'd1 || ex_valid_o !== 1'b1) begin
      failed++; $display("FAIL first_add: op1=%h op2=%h func=%h v=%b expected 5 7 1 1",
        alu_op1_o, alu_op2_o, alu_func_o, ex_valid_o);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk_i);
    set_id(1, 32'h300, 5'd1, 5'd2, 5'd3, 1, 1, 32'd1, 32'd2, 32'd0, 4'd1, 2'd0, 1'b0, 1, 0, 0);
    @(negedge clk_i);
    set_id(1, 32'h304, 5'd3, 5'd2, 5'd4, 1, 1, 32'h999, 32'd2, 32'd0, 4'd2, 2'd0, 1'b0, 1, 0, 0);
    @(posedge clk_i); #1;
    exm_rd_i = 5'd3; exm_we_i = 1; exm_data_i = 32'h10;
    mwb_rd_i = 5'd3; mwb_we_i = 1; mwb_data_i = 32'h20;
    #1;
    tests++;
    if (alu_op1_o !== 32'h10) begin
      failed++; $display("FAIL fwd_exm_priority: got %h expected 00000010", alu_op1_o);
    end
    tests++;
    if (alu_func_o !== 4'd2 || alu_op2_o !== 32'd2) begin
      failed++; $display("FAIL sub_fields: func=%h op2=%h expected 2 2", alu_func_o, alu_op2_o);
    end
    exm_we_i = 0; #1;
    tests++;
    if (alu_op1_o !== 32'h20) begin
      failed++; $display("FAIL fwd_mwb: got %h expected 00000020", alu_op1_o);
    end
    mwb_we_i = 0; #1;
    tests++;
    if (alu_op1_o !== 32'h999) begin
      failed++; $display("FAIL fwd_none: got %h expected 00000999", alu_op1_o);
    end
    clr_fwd();
  endtask

  task automatic test_x0();
    @(negedge clk_i);
    set_id(1, 32'h400, 5'd0, 5'd0, 5'd6, 1, 1, 32'd0, 32'd0, 32'd0, 4'd7, 2'd0, 1'b0, 1, 0, 0);
    @(posedge clk_i); #1;
    exm_rd_i = 5'd0; exm_we_i = 1; exm_data_i = 32'hFFFF_FFFF;
    mwb_rd_i = 5'd0; mwb_we_i = 1; mwb_data_i = 32'hFFFF_FFFF;
    #1;
    tests++;
    if (alu_op1_o !== 32'd0 || alu_op2_o !== 32'd0) begin
      failed++; $display("FAIL x0_no_fwd: op1=%h op2=%h expected 0 0", alu_op1_o, alu_op2_o);
    end
    clr_fwd();
  endtask

  task automatic test_load_use();
    @(negedge clk_i);
    set_id(1, 32'h500, 5'd1, 5'd0, 5'd5, 1, 0, 32'h100, 32'd0, 32'd4, 4'd1, 2'd0, 1'b1, 1, 1, 0);
    @(negedge clk_i);
    set_id(1, 32'h504, 5'd5, 5'd7, 5'd6, 1, 1, 32'd0, 32'd3, 32'd0, 4'd1, 2'd0, 1'b0, 1, 0, 0);
    #1;
    tests++;
    if (id_stall_o !== 1'b1 || ex_mem_rd_o !== 1'b1) begin
      failed++; $display("FAIL lu_stall: stall=%b memrd=%b expected 1 1", id_stall_o, ex_mem_rd_o);
    end
    @(posedge clk_i); #1;
    tests++;
    if (ex_valid_o !== 1'b0 || alu_func_o !== 4'd0 || id_stall_o !== 1'b0) begin
      failed++; $display("FAIL lu_bubble: v=%b func=%h stall=%b expected 0 0 0",
        ex_valid_o, alu_func_o, id_stall_o);
    end
    @(posedge clk_i); #1;
    mwb_rd_i = 5'd5; mwb_we_i = 1; mwb_data_i = 32'hAB;
    #1;
    tests++;
    if (alu_op1_o !== 32'hAB || ex_valid_o !== 1'b1 || ex_pc_o !== 32'h504) begin
      failed++; $display("FAIL lu_fwd: op1=%h v=%b pc=%h expected ab 1 504",
        alu_op1_o, ex_valid_o, ex_pc_o);
    end
    clr_fwd();
  endtask

  task automatic test_flush();
    @(negedge clk_i);
    set_id(1, 32'h600, 5'd1, 5'd2, 5'd8, 1, 1, 32'd1, 32'd2, 32'd0, 4'd6, 2'd0, 1'b0, 1, 0, 1);
    flush_i = 1;
    @(posedge clk_i); #1;
    tests++;
    if (ex_valid_o !== 1'b0 || ex_reg_we_o !== 1'b0 || ex_mem_wr_o !== 1'b0) begin
      failed++; $display("FAIL flush_bubble: v=%b we=%b mwr=%b expected 0 0 0",
        ex_valid_o, ex_reg_we_o, ex_mem_wr_o);
    end
    // Load in EX followed by a dependent instruction that is being flushed.
    @(negedge clk_i);
    flush_i = 0;
    set_id(1, 32'h610, 5'd1, 5'd0, 5'd9, 1, 0, 32'h40, 32'd0, 32'd0, 4'd1, 2'd0, 1'b1, 1, 1, 0);
    @(negedge clk_i);
    set_id(1, 32'h614, 5'd2, 5'd9, 5'd10, 1, 1, 32'd0, 32'd0, 32'd0, 4'd1, 2'd0, 1'b0, 1, 0, 0);
    flush_i = 1;
    #1;
    tests++;
    if (id_stall_o !== 1'b0) begin
      failed++; $display("FAIL flush_lu_stall: got %b expected 0", id_stall_o);
    end
    @(posedge clk_i); #1;
    tests++;
    if (ex_valid_o !== 1'b0 || ex_mem_rd_o !== 1'b0) begin
      failed++; $display("FAIL flush_lu_bubble: v=%b memrd=%b expected 0 0", ex_valid_o, ex_mem_rd_o);
    end
    @(negedge clk_i);
    flush_i = 0;
  endtask

  task automatic test_mem_stall();
    @(negedge clk_i);
    set_id(1, 32'h40, 5'd1, 5'd9, 5'd0, 1, 1, 32'h200, 32'h55, 32'd8, 4'd1, 2'd0, 1'b1, 0, 0, 1);
    @(negedge clk_i);
    set_id(1, 32'h44, 5'd3, 5'd4, 5'd11, 1, 1, 32'd0, 32'd0, 32'd0, 4'd1, 2'd0, 1'b0, 1, 0, 0);
    mem_stall_i = 1;
    mwb_rd_i = 5'd9; mwb_we_i = 1;
    for (int i = 0; i < 3; i++) begin
      mwb_data_i = 32'h1000 + i;
      flush_i = (i == 1);
      #1;
      tests++;
      if (ex_pc_o !== 32'h40 || id_stall_o !== 1'b1 || ex_mem_wr_o !== 1'b1) begin
        failed++; $display("FAIL stall_hold[%0d]: pc=%h stall=%b mwr=%b expected 40 1 1",
          i, ex_pc_o, id_stall_o, ex_mem_wr_o);
      end
      tests++;
      if (ex_store_data_o !== 32'h1000 + i || alu_op2_o !== 32'd8) begin
        failed++; $display("FAIL stall_fwd[%0d]: st=%h op2=%h expected %h 8",
          i, ex_store_data_o, alu_op2_o, 32'h1000 + i);
      end
      @(negedge clk_i);
    end
    mem_stall_i = 0; flush_i = 0; clr_fwd();
    @(posedge clk_i); #1;
    tests++;
    if (ex_pc_o !== 32'h44 || ex_valid_o !== 1'b1) begin
      failed++; $display("FAIL stall_release: pc=%h v=%b expected 44 1", ex_pc_o, ex_valid_o);
    end
  endtask

  task automatic test_reset_mid_stall();
    @(negedge clk_i);
    mem_stall_i = 1;
    #2;
    rst_n_i = 0;
    #1;
    tests++;
    if (ex_valid_o !== 1'b0 || ex_pc_o !== 32'd0 || alu_func_o !== 4'd0 || id_stall_o !== 1'b1) begin
      failed++; $display("FAIL async_reset: v=%b pc=%h func=%h stall=%b expected 0 0 0 1",
        ex_valid_o, ex_pc_o, alu_func_o, id_stall_o);
    end
    @(negedge clk_i);
    rst_n_i = 1; mem_stall_i = 0;
  endtask

  initial begin
    clr_fwd();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_back_to_back();
    test_x0();
    test_load_use();
    test_flush();
    test_mem_stall();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with EX-stage operand forwarding and load-use hazard detection for the RV32I pipeline. It captures decoded instructions from the decode stage and drives the ALU operands and function code directly: alu_op1_o, alu_op2_o and alu_func_o feed the ALU's op1_i, op2_i and func_i. It also carries the memory and writeback control fields on to the EX/MEM register and generates the decode-stage stall.

## Interface
- No parameters; datapath fixed at 32 bits, register index 5 bits.
- clk_i  in  1  clock, all state updates on rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- id_valid_i  in  1  decode stage holds a real instruction.
- id_pc_i  in  32  instruction PC.
- id_rs1_i, id_rs2_i, id_rd_i  in  5 each  register indices.
- id_uses_rs1_i, id_uses_rs2_i  in  1 each  instruction actually reads rs1 / rs2.
- id_rs1_data_i, id_rs2_data_i  in  32 each  register-file read data.
- id_imm_i  in  32  sign-extended immediate.
- id_alu_func_i  in  4  ALU function code:
  - 1 add, 2 sub, 3 sll, 4 srl, 5 sra, 6 and, 7 or, 8 xor, 9 slt, 10 sltu, 11 pass op1.
  - 0 and 12-15 produce zero.
- id_op1_sel_i  in  2  operand-1 source: 00 rs1, 01 pc, 10 zero, 11 zero.
- id_op2_sel_i  in  1  operand-2 source: 0 rs2, 1 imm.
- id_reg_we_i, id_mem_rd_i, id_mem_wr_i  in  1 each  writeback / load / store controls.
- exm_rd_i, exm_we_i, exm_data_i  in  5/1/32  EX/MEM destination, write enable, ALU result.
- mwb_rd_i, mwb_we_i, mwb_data_i  in  5/1/32  MEM/WB destination, write enable, final writeback data.
- flush_i  in  1  kill the instruction in decode (taken branch or jump).
- mem_stall_i  in  1  downstream stall; hold the EX stage.
- id_stall_o  out  1  decode and fetch must hold.
- ex_valid_o  out  1  EX stage holds a real instruction.
- ex_pc_o  out  32  PC of the EX instruction.
- alu_op1_o, alu_op2_o, alu_func_o  out  32/32/4  ALU inputs.
- ex_store_data_o  out  32  forwarded rs2 value for stores.
- ex_rd_o  out  5  destination index.
- ex_reg_we_o, ex_mem_rd_o, ex_mem_wr_o  out  1 each  gated controls.

## Operation
- Registered EX fields: valid, pc, rs1, rs2, rd, rs1_data, rs2_data, imm, func, op1_sel, op2_sel, reg_we, mem_rd, mem_wr.
- Load-use hazard: lu = ex_valid & ex_mem_rd & (ex_rd != 0) & id_valid_i & ((id_uses_rs1_i & id_rs1_i == ex_rd) | (id_uses_rs2_i & id_rs2_i == ex_rd)).
- Update priority on each edge:
  1. mem_stall_i: hold all fields.
  2. flush_i: load a bubble.
  3. lu: load a bubble.
  4. Otherwise: capture all ID inputs, with valid = id_valid_i.
- A bubble clears valid, reg_we, mem_rd, mem_wr and func; the other fields are don't-care but are cleared.
- id_stall_o = mem_stall_i | (lu & ~flush_i).
- Forwarding, combinational, applied per source register (fwd_rs1, fwd_rs2):
  - Use exm_data_i if exm_we_i & exm_rd_i != 0 & exm_rd_i == ex_rs.
  - Else use mwb_data_i if mwb_we_i & mwb_rd_i != 0 & mwb_rd_i == ex_rs.
  - Else use the registered data.
  - EX/MEM has priority over MEM/WB. x0 is never forwarded.
- alu_op1_o = op1_sel 00 → fwd_rs1; 01 → ex_pc; 10/11 → 0.
- alu_op2_o = op2_sel 0 → fwd_rs2; 1 → ex_imm.
- ex_store_data_o = fwd_rs2, regardless of op2_sel.
- When ex_valid_o = 0: alu_func_o = 0 and ex_reg_we_o / ex_mem_rd_o / ex_mem_wr_o = 0.

## Timing
- Reset (asynchronous assert, synchronous release) clears every register. Resulting outputs:
  - ex_valid_o = 0, alu_func_o = 0, alu_op1_o = alu_op2_o = 0 (x0 is not forwarded).
  - ex_pc_o = 0, ex_rd_o = 0, all controls = 0, ex_store_data_o = 0.
  - id_stall_o = mem_stall_i.
- Latency: ID inputs appear at EX outputs one cycle after capture. Forward paths are zero-cycle.
- A load-use dependency costs exactly one bubble. The dependent instruction then forwards from MEM/WB.
- mem_stall_i held N cycles: EX outputs frozen N cycles; forwarding still tracks the live exm/mwb inputs.
- flush_i and lu together: bubble, with id_stall_o = 0 (the decode instruction is discarded).
- mem_stall_i and flush_i together: hold. flush_i must remain asserted by its source until it is accepted.
- Reset asserted mid-stall: outputs return to their reset values immediately.

## Test plan
- Reset with rst_n_i = 0 while inputs toggle → all outputs at reset values; after release, add x1 = 5 + imm 7 → next cycle alu_op1_o = 5, alu_op2_o = 7, alu_func_o = 1, ex_valid_o = 1.
- Back-to-back add x3 then sub x4, x3, x2 with exm_rd_i = 3, exm_data_i = 0x10, and mwb_rd_i = 3, mwb_data_i = 0x20 → alu_op1_o = 0x10 (EX/MEM wins).
- exm_rd_i = 0, exm_we_i = 1, exm_data_i = 0xFFFF_FFFF with an EX instruction reading x0 → alu_op1_o = 0.
- Load x5 in EX, add reading x5 in decode → id_stall_o = 1 for one cycle, then bubble (ex_valid_o = 0, alu_func_o = 0). Next cycle the add is in EX with mwb_rd_i = 5, mwb_data_i = 0xAB → alu_op1_o = 0xAB.
- flush_i = 1 with a valid decode instruction → next cycle ex_valid_o = 0, ex_reg_we_o = 0, ex_mem_wr_o = 0.
- mem_stall_i = 1 for 3 cycles with a store in EX → ex_pc_o unchanged and id_stall_o = 1 throughout; ex_store_data_o follows a changing mwb_data_i when mwb_rd_i matches rs2.
